// File: rtl/rvc_expand_stage_if.sv
// Stream bundle between the instruction realigner, the RVC expansion stage and decode.
// The master side drives the offer, flush and decode-ready; the slave side is the stage.
interface rvc_expand_stage_if;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_is_compressed;
   logic        out_illegal;

   modport master (
      output flush, in_valid, in_pc, in_inst, out_ready,
      input  in_ready, out_valid, out_pc, out_inst, out_is_compressed, out_illegal
   );

   modport slave (
      input  flush, in_valid, in_pc, in_inst, out_ready,
      output in_ready, out_valid, out_pc, out_inst, out_is_compressed, out_illegal
   );
endinterface

// File: rtl/rvc_expand_stage.sv
// RV32C expansion stage: expands 16-bit encodings to 32 bits and buffers them in a 2-entry FIFO.
// Define RVC_FP_EN to expand the C.FLW/FSW/FLD/FSD family; otherwise they are flagged illegal.
module rvc_expand_stage (
   input  logic               clk,
   input  logic               reset,
   rvc_expand_stage_if.slave  bus
);
`ifdef RVC_FP_EN
   localparam bit FP_EN = 1'b1;
`else
   localparam bit FP_EN = 1'b0;
`endif

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [6:0] op);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
   endfunction

   // Branch and jump immediates are passed without their always-zero bit 0.
   function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3);
      return {imm[12], imm[10:5], 5'd0, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
   endfunction

   logic [15:0] c;
   logic [4:0]  rd;
   logic [4:0]  rs2;
   logic [4:0]  rs1p;
   logic [4:0]  rs2p;
   logic [11:0] imm6;
   logic [2:0]  alu_f3;
   logic [6:0]  alu_f7;
   logic [31:0] x_inst;
   logic        x_ill;
   logic        is_comp;
   logic        is_ill;
   logic [31:0] wr_inst;

   always_comb begin
      c      = bus.in_inst[15:0];
      rd     = c[11:7];
      rs2    = c[6:2];
      rs1p   = {2'b01, c[9:7]};
      rs2p   = {2'b01, c[4:2]};
      imm6   = {{7{c[12]}}, c[6:2]};
      alu_f7 = (c[6:5] == 2'b00) ? 7'b0100000 : 7'b0000000;
      case (c[6:5])
         2'b00:   alu_f3 = 3'b000;
         2'b01:   alu_f3 = 3'b100;
         2'b10:   alu_f3 = 3'b110;
         default: alu_f3 = 3'b111;
      endcase
      x_inst = 32'h0;
      x_ill  = 1'b0;
      case (c[1:0])
         2'b00: case (c[15:13])
            3'b000: begin
               x_inst = enc_i({2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00}, 5'd2, 3'b000, rs2p, OPC_OP_IMM);
               x_ill  = (c[12:5] == 8'h00);
            end
            3'b001: begin
               x_inst = enc_i({4'b0, c[6:5], c[12:10], 3'b000}, rs1p, 3'b011, rs2p, OPC_LOAD_FP);
               x_ill  = !FP_EN;
            end
            3'b010: x_inst = enc_i({5'b0, c[5], c[12:10], c[6], 2'b00}, rs1p, 3'b010, rs2p, OPC_LOAD);
            3'b011: begin
               x_inst = enc_i({5'b0, c[5], c[12:10], c[6], 2'b00}, rs1p, 3'b010, rs2p, OPC_LOAD_FP);
               x_ill  = !FP_EN;
            end
            3'b101: begin
               x_inst = enc_s({4'b0, c[6:5], c[12:10], 3'b000}, rs2p, rs1p, 3'b011, OPC_STORE_FP);
               x_ill  = !FP_EN;
            end
            3'b110: x_inst = enc_s({5'b0, c[5], c[12:10], c[6], 2'b00}, rs2p, rs1p, 3'b010, OPC_STORE);
            3'b111: begin
               x_inst = enc_s({5'b0, c[5], c[12:10], c[6], 2'b00}, rs2p, rs1p, 3'b010, OPC_STORE_FP);
               x_ill  = !FP_EN;
            end
            default: x_ill = 1'b1;
         endcase
         2'b01: case (c[15:13])
            3'b000: x_inst = enc_i(imm6, rd, 3'b000, rd, OPC_OP_IMM);
            3'b001: x_inst = enc_j({{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3]}, 5'd1);
            3'b010: x_inst = enc_i(imm6, 5'd0, 3'b000, rd, OPC_OP_IMM);
            3'b011: begin
               // rd=x2 selects C.ADDI16SP; a zero immediate is reserved for both forms
               if (rd == 5'd2)
                  x_inst = enc_i({{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000}, 5'd2, 3'b000, 5'd2, OPC_OP_IMM);
               else
                  x_inst = {{15{c[12]}}, c[6:2], rd, OPC_LUI};
               x_ill = ({c[12], c[6:2]} == 6'd0);
            end
            3'b100: case (c[11:10])
               2'b00: begin
                  x_inst = enc_r(7'b0000000, c[6:2], rs1p, 3'b101, rs1p, OPC_OP_IMM);
                  x_ill  = c[12];
               end
               2'b01: begin
                  x_inst = enc_r(7'b0100000, c[6:2], rs1p, 3'b101, rs1p, OPC_OP_IMM);
                  x_ill  = c[12];
               end
               2'b10: x_inst = enc_i(imm6, rs1p, 3'b111, rs1p, OPC_OP_IMM);
               default: begin
                  x_inst = enc_r(alu_f7, rs2p, rs1p, alu_f3, rs1p, OPC_OP);
                  x_ill  = c[12];
               end
            endcase
            3'b101: x_inst = enc_j({{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3]}, 5'd0);
            3'b110: x_inst = enc_b({{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3]}, rs1p, 3'b000);
            default: x_inst = enc_b({{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3]}, rs1p, 3'b001);
         endcase
         2'b10: case (c[15:13])
            3'b000: begin
               x_inst = enc_r(7'b0000000, c[6:2], rd, 3'b001, rd, OPC_OP_IMM);
               x_ill  = c[12];
            end
            3'b001: begin
               x_inst = enc_i({3'b0, c[4:2], c[12], c[6:5], 3'b000}, 5'd2, 3'b011, rd, OPC_LOAD_FP);
               x_ill  = !FP_EN;
            end
            3'b010: begin
               x_inst = enc_i({4'b0, c[3:2], c[12], c[6:4], 2'b00}, 5'd2, 3'b010, rd, OPC_LOAD);
               x_ill  = (rd == 5'd0);
            end
            3'b011: begin
               x_inst = enc_i({4'b0, c[3:2], c[12], c[6:4], 2'b00}, 5'd2, 3'b010, rd, OPC_LOAD_FP);
               x_ill  = !FP_EN;
            end
            3'b100: begin
               if (!c[12]) begin
                  if (rs2 == 5'd0) begin
                     x_inst = enc_i(12'h000, rd, 3'b000, 5'd0, OPC_JALR);
                     x_ill  = (rd == 5'd0);
                  end else begin
                     x_inst = enc_r(7'b0000000, rs2, 5'd0, 3'b000, rd, OPC_OP);
                  end
               end else if (rs2 == 5'd0) begin
                  x_inst = (rd == 5'd0) ? 32'h00100073 : enc_i(12'h000, rd, 3'b000, 5'd1, OPC_JALR);
               end else begin
                  x_inst = enc_r(7'b0000000, rs2, rd, 3'b000, rd, OPC_OP);
               end
            end
            3'b101: begin
               x_inst = enc_s({3'b0, c[9:7], c[12:10], 3'b000}, rs2, 5'd2, 3'b011, OPC_STORE_FP);
               x_ill  = !FP_EN;
            end
            3'b110: x_inst = enc_s({4'b0, c[8:7], c[12:9], 2'b00}, rs2, 5'd2, 3'b010, OPC_STORE);
            default: begin
               x_inst = enc_s({4'b0, c[8:7], c[12:9], 2'b00}, rs2, 5'd2, 3'b010, OPC_STORE_FP);
               x_ill  = !FP_EN;
            end
         endcase
         default: x_inst = bus.in_inst;
      endcase
      is_comp = (c[1:0] != 2'b11);
      is_ill  = is_comp && x_ill;
      wr_inst = is_ill ? {16'h0000, c} : x_inst;
   end

   // FIFO entry layout: {pc[65:34], inst[33:2], is_compressed[1], illegal[0]}
   logic [1:0]  count_reg;
   logic        wr_ptr_reg;
   logic        rd_ptr_reg;
   logic        push;
   logic        pop;
   logic [65:0] wr_entry;
   logic [65:0] head;

   assign bus.in_ready  = (count_reg != 2'd2);
   assign bus.out_valid = (count_reg != 2'd0);
   assign push          = bus.in_valid && bus.in_ready;
   assign pop           = bus.out_valid && bus.out_ready;
   assign wr_entry      = {bus.in_pc, wr_inst, is_comp, is_ill};

   always_ff @(posedge clk) begin
      if (reset || bus.flush) begin
         count_reg  <= 2'd0;
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
      end else begin
         if (push)
            wr_ptr_reg <= !wr_ptr_reg;
         if (pop)
            rd_ptr_reg <= !rd_ptr_reg;
         count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      logic [65:0] entry_reg;
      always_ff @(posedge clk) begin
         if (reset)
            entry_reg <= '0;
         else if (push && !bus.flush && (wr_ptr_reg == 1'(gi)))
            entry_reg <= wr_entry;
      end
   end

   assign head                  = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;
   assign bus.out_pc            = head[65:34];
   assign bus.out_inst          = head[33:2];
   assign bus.out_is_compressed = head[1];
   assign bus.out_illegal       = head[0];
endmodule

// File: doc/rvc_expand_stage.md
RVC_EXPAND_STAGE -- requirements
Module: rvc_expand_stage

Interface
REQ-001 SHALL have input clk, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have input reset, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have input flush, 1 bit: discards all buffered entries (branch/jump redirect).
REQ-004 SHALL have input in_valid, 1 bit: upstream realigner offers an instruction.
REQ-005 SHALL have output in_ready, 1 bit: the stage accepts the offered instruction this cycle.
REQ-006 SHALL have input in_pc, 32 bits: PC of the offered instruction.
REQ-007 SHALL have input in_inst, 32 bits: realigned instruction word; compressed instructions occupy bits [15:0].
REQ-008 SHALL have output out_valid, 1 bit: an expanded instruction is presented to decode.
REQ-009 SHALL have input out_ready, 1 bit: decode consumes the presented instruction.
REQ-010 SHALL have output out_pc, 32 bits: PC of the presented instruction.
REQ-011 SHALL have output out_inst, 32 bits: expanded 32-bit instruction.
REQ-012 SHALL have output out_is_compressed, 1 bit: the source instruction was 16-bit (next sequential PC is +2).
REQ-013 SHALL have output out_illegal, 1 bit: the source encoding is illegal or reserved.

Function
REQ-014 SHALL use 2-entry FIFO storage holding {pc, expanded inst, is_compressed, illegal}; expansion is computed combinationally on in_inst before the write.
REQ-015 SHALL perform a push when in_valid && in_ready, and a pop when out_valid && out_ready.
REQ-016 SHALL drive in_ready = (count < 2), decoded from registered count only; in_valid SHALL NOT affect in_ready.
REQ-017 SHALL drive out_valid = (count != 0) and present the head entry; minimum latency is 1 cycle from push to out_valid.
REQ-018 SHALL allow a push and a pop in the same cycle when count == 1; count stays 1 and order is preserved.
REQ-019 SHALL keep head entry outputs stable while out_valid && !out_ready.
REQ-020 SHALL wrap the read/write pointers modulo 2, with no loss or duplication across wrap.
REQ-021 SHALL, on flush, set count to 0 on the next edge; flush dominates any same-cycle push or pop, and the pushed word is dropped.
REQ-022 SHALL treat in_inst[1:0] == 2'b11 as non-compressed: store it unchanged, with is_compressed=0 and illegal=0.
REQ-023 SHALL expand all RV32C quadrant 0/1/2 encodings (RISC-V unprivileged ISA, RVC chapter) to their 32-bit equivalents and set is_compressed=1.
REQ-024 SHALL classify the following as illegal: in_inst[15:0] == 16'h0000, C.ADDI4SPN with nzuimm=0, C.LUI/C.ADDI16SP with imm=0, C.LUI with rd=x2 handled as C.ADDI16SP, C.JR with rs1=x0, RV64/128-only encodings, and reserved encodings.
REQ-025 SHALL, for an illegal encoding, store illegal=1 and out_inst = {16'h0000, in_inst[15:0]}.
REQ-026 SHALL expand HINT encodings (e.g. C.NOP with imm≠0, C.LI with rd=x0) normally and not flag them illegal.

Reset
REQ-027 SHALL, while reset is high, clear count and both pointers, giving out_valid=0 and in_ready=1 on the following cycle.
REQ-028 SHALL reset out_pc, out_inst, out_is_compressed and out_illegal to 0; reset mid-transfer discards all entries and ignores in_valid.

Configuration
REQ-029 SHALL, when RVC_FP_EN is defined, expand C.FLW, C.FSW, C.FLWSP, C.FSWSP, C.FLD, C.FSD, C.FLDSP and C.FSDSP to FLW, FSW, FLD and FSD.
REQ-030 SHALL, when RVC_FP_EN is undefined, flag those eight encodings illegal per REQ-025; all other behaviour is identical.

Verification
REQ-031 SHALL cover expansion: push 16'h4501, 16'h0505, 16'h0001, 16'h8082, 16'h4108 -> out_inst 32'h00000513, 32'h00150513, 32'h00000013, 32'h00008067, 32'h00052503, each with out_is_compressed=1.
REQ-032 SHALL cover passthrough: push 32'h00A50533 -> out_inst 32'h00A50533, out_is_compressed=0, out_illegal=0, out_pc equal to in_pc.
REQ-033 SHALL cover illegal encodings: push 16'h0000 and 16'h8002 -> out_illegal=1, out_inst 32'h00000000 and 32'h00008002.
REQ-034 SHALL cover backpressure: hold out_ready=0 and push 3 words -> in_ready=0 after 2 pushes, the third is held upstream; release out_ready -> all 3 words delivered in order.
REQ-035 SHALL cover flush: with 2 entries buffered, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, and the pushed word never appears.
REQ-036 SHALL cover configuration: push 16'h6108 -> with RVC_FP_EN, out_inst 32'h00052507; without it, out_illegal=1.
